// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the sequential matrix ALU.
// Covers opcodes, FSM states, flat-bus indexing and width reduction of results.
package matrix_alu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP       = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_ADD       = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_SUB       = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_MUL       = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_OPPOSITE  = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_TRANSPOSE = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_SCALAR    = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_DET       = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic int idx(input int r, input int c, input int max_n);
        return r * max_n + c;
    endfunction

    function automatic logic elem_overflow(input longint value, input int data_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (data_w - 1)) - 1;
        lo = -(longint'(1) <<< (data_w - 1));
        return (value > hi) || (value < lo);
    endfunction

    // The caller keeps the low data_w bits; in wrap mode that is plain truncation.
    function automatic longint saturate(input longint value, input int data_w, input logic sat_mode);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (data_w - 1)) - 1;
        lo = -(longint'(1) <<< (data_w - 1));
        if (sat_mode && (value > hi)) begin
            return hi;
        end
        if (sat_mode && (value < lo)) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/matrix_alu_seq_if.sv
// Request/response bundle of the sequential matrix ALU.
// The master side issues operations and the slave side is the ALU.
interface matrix_alu_seq_if
    import matrix_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5,
    parameter int SIZE_W = $clog2(MAX_N + 1)
) ();

    localparam int FLAT_W = MAX_N * MAX_N * DATA_W;

    logic                start;
    logic [OPCODE_W-1:0] opcode;
    logic [SIZE_W-1:0]   matrix_size;
    logic                sat_mode;
    logic [DATA_W-1:0]   scalar;
    logic [FLAT_W-1:0]   A_flat;
    logic [FLAT_W-1:0]   B_flat;
    logic [FLAT_W-1:0]   C_flat;
    logic                busy;
    logic                done;
    logic                overflow_flag;
    logic                error;

    modport master (
        output start, opcode, matrix_size, sat_mode, scalar, A_flat, B_flat,
        input  C_flat, busy, done, overflow_flag, error
    );

    modport slave (
        input  start, opcode, matrix_size, sat_mode, scalar, A_flat, B_flat,
        output C_flat, busy, done, overflow_flag, error
    );

endinterface

// File: rtl/matrix_elem_unit.sv
// Combinational element datapath.
// Forms one full-precision result, then reduces it to DATA_W with overflow detection.
module matrix_elem_unit
    import matrix_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5
) (
    input  logic [OPCODE_W-1:0]                              opcode,
    input  logic signed [DATA_W-1:0]                         a,
    input  logic signed [DATA_W-1:0]                         b,
    input  logic signed [DATA_W-1:0]                         scalar,
    input  logic signed [2*DATA_W+$clog2(MAX_N)-1:0]         accumulator,
    input  logic                                             sat_mode,
    output logic [DATA_W-1:0]                                result,
    output logic                                             elem_ovf
);

    localparam int ACC_W = 2 * DATA_W + $clog2(MAX_N);

    logic signed [ACC_W-1:0] full;

    // For multiply, the top has already summed the products into accumulator.
    always_comb begin
        full = '0;
        case (opcode)
            OP_ADD:       full = ACC_W'(a) + ACC_W'(b);
            OP_SUB:       full = ACC_W'(a) - ACC_W'(b);
            OP_MUL:       full = accumulator;
            OP_OPPOSITE:  full = -ACC_W'(a);
            OP_TRANSPOSE: full = ACC_W'(a);
            OP_SCALAR:    full = ACC_W'(scalar) * ACC_W'(a);
            default:      full = '0;
        endcase
        elem_ovf = elem_overflow(longint'(full), DATA_W);
        result   = DATA_W'(saturate(longint'(full), DATA_W, sat_mode));
    end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential matrix ALU: one result element, or one multiply-accumulate step, per clock.
// The FSM, the r/c/k counters and the accumulator live here.
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5,
    parameter int SIZE_W = $clog2(MAX_N + 1)
) (
    input  logic            clock,
    input  logic            reset,
    matrix_alu_seq_if.slave bus
);

    localparam int FLAT_W = MAX_N * MAX_N * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(MAX_N);

    state_t state;
    state_t state_next;

    logic [FLAT_W-1:0]        a_reg;
    logic [FLAT_W-1:0]        b_reg;
    logic [FLAT_W-1:0]        c_reg;
    logic signed [DATA_W-1:0] scalar_reg;
    logic [OPCODE_W-1:0]      op_reg;
    logic [SIZE_W-1:0]        n_reg;
    logic                     sat_reg;
    logic                     ovf_reg;
    logic                     err_reg;
    logic [SIZE_W-1:0]        row;
    logic [SIZE_W-1:0]        col;
    logic [SIZE_W-1:0]        kk;
    logic signed [ACC_W-1:0]  acc;

    logic [SIZE_W-1:0]        n_last;
    logic                     req_bad;
    logic                     elem_done;
    logic                     last_step;
    logic signed [DATA_W-1:0] a_sel;
    logic signed [DATA_W-1:0] b_sel;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0]        elem_result;
    logic                     elem_ovf;

    assign n_last    = n_reg - SIZE_W'(1);
    assign req_bad   = (bus.matrix_size == '0) || (bus.matrix_size > SIZE_W'(MAX_N)) || (bus.opcode == OP_DET);
    assign elem_done = (op_reg != OP_MUL) || (kk == n_last);
    assign last_step = (row == n_last) && (col == n_last) && elem_done;

    // Multiply walks A along row r and B down column c; transpose reads A mirrored.
    always_comb begin
        a_sel = a_reg[idx(int'(row), int'(col), MAX_N) * DATA_W +: DATA_W];
        b_sel = b_reg[idx(int'(row), int'(col), MAX_N) * DATA_W +: DATA_W];
        if (op_reg == OP_MUL) begin
            a_sel = a_reg[idx(int'(row), int'(kk), MAX_N) * DATA_W +: DATA_W];
            b_sel = b_reg[idx(int'(kk), int'(col), MAX_N) * DATA_W +: DATA_W];
        end else if (op_reg == OP_TRANSPOSE) begin
            a_sel = a_reg[idx(int'(col), int'(row), MAX_N) * DATA_W +: DATA_W];
        end
        prod    = ACC_W'(a_sel) * ACC_W'(b_sel);
        acc_sum = ((kk == '0) ? '0 : acc) + prod;
    end

    matrix_elem_unit #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N)
    ) u_elem (
        .opcode      (op_reg),
        .a           (a_sel),
        .b           (b_sel),
        .scalar      (scalar_reg),
        .accumulator (acc_sum),
        .sat_mode    (sat_reg),
        .result      (elem_result),
        .elem_ovf    (elem_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Illegal requests and NOP skip CALC and report straight away.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (req_bad || (bus.opcode == OP_NOP)) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            scalar_reg <= '0;
            op_reg     <= OP_NOP;
            n_reg      <= '0;
            sat_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
            row        <= '0;
            col        <= '0;
            kk         <= '0;
            acc        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg      <= bus.A_flat;
                        b_reg      <= bus.B_flat;
                        scalar_reg <= bus.scalar;
                        op_reg     <= bus.opcode;
                        n_reg      <= bus.matrix_size;
                        sat_reg    <= bus.sat_mode;
                        c_reg      <= '0;
                        ovf_reg    <= 1'b0;
                        err_reg    <= req_bad;
                        row        <= '0;
                        col        <= '0;
                        kk         <= '0;
                        acc        <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    if (elem_done) begin
                        c_reg[idx(int'(row), int'(col), MAX_N) * DATA_W +: DATA_W] <= elem_result;
                        if (elem_ovf) begin
                            ovf_reg <= 1'b1;
                        end
                        kk <= '0;
                        if (col == n_last) begin
                            col <= '0;
                            row <= row + SIZE_W'(1);
                        end else begin
                            col <= col + SIZE_W'(1);
                        end
                    end else begin
                        kk <= kk + SIZE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.C_flat        = c_reg;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.overflow_flag = ovf_reg;
    assign bus.error         = err_reg;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Randomised scoreboard bench for matrix_alu_seq.
// Expected results come from integer matrix arithmetic and are checked whenever done pulses.
module tb_matrix_alu_seq;
    import matrix_alu_pkg::*;

    localparam int DATA_W   = 8;
    localparam int MAX_N    = 5;
    localparam int SIZE_W   = $clog2(MAX_N + 1);
    localparam int FLAT_W   = MAX_N * MAX_N * DATA_W;
    localparam int MAX_WAIT = 400;

    typedef struct {
        logic [FLAT_W-1:0] c;
        logic              ovf;
        logic              err;
        int                lat;
        int                start_cyc;
        int                id;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests_run = 0;
    int   failed = 0;
    int   next_id = 0;
    logic prev_done = 1'b0;
    exp_t exp_q[$];
    int   ma [MAX_N][MAX_N];
    int   mb [MAX_N][MAX_N];

    matrix_alu_seq_if #(.DATA_W(DATA_W), .MAX_N(MAX_N)) bus ();

    matrix_alu_seq #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string what, input int id, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s (op %0d): got %h expected %h", what, id, act, exp);
        end
    endtask

    // Reference model: plain integer matrix maths, then reduction to DATA_W.
    function automatic void model(input int op, input int n, input bit sat, input int s, output exp_t e);
        int v;
        int hi;
        int lo;
        hi    = (1 <<< (DATA_W - 1)) - 1;
        lo    = -(1 <<< (DATA_W - 1));
        e.c   = '0;
        e.ovf = 1'b0;
        e.err = (n < 1) || (n > MAX_N) || (op == 7);
        e.lat = -1;
        e.start_cyc = 0;
        e.id  = 0;
        if (!e.err && op != 0) begin
            e.lat = (op == 3) ? n * n * n : n * n;
            for (int r = 0; r < n; r++) begin
                for (int c = 0; c < n; c++) begin
                    v = 0;
                    case (op)
                        1: v = ma[r][c] + mb[r][c];
                        2: v = ma[r][c] - mb[r][c];
                        3: for (int k = 0; k < n; k++) v += ma[r][k] * mb[k][c];
                        4: v = -ma[r][c];
                        5: v = ma[c][r];
                        6: v = s * ma[r][c];
                        default: v = 0;
                    endcase
                    if (v > hi || v < lo) e.ovf = 1'b1;
                    if (sat && v > hi) v = hi;
                    if (sat && v < lo) v = lo;
                    e.c[(r * MAX_N + c) * DATA_W +: DATA_W] = DATA_W'(v);
                end
            end
        end
    endfunction

    task automatic loadOperands();
        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                bus.A_flat[(r * MAX_N + c) * DATA_W +: DATA_W] = DATA_W'(ma[r][c]);
                bus.B_flat[(r * MAX_N + c) * DATA_W +: DATA_W] = DATA_W'(mb[r][c]);
            end
        end
    endtask

    task automatic randomFill(input bit wide);
        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                ma[r][c] = wide ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
                mb[r][c] = wide ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
            end
        end
    endtask

    task automatic set2(input int a00, input int a01, input int a10, input int a11,
                        input int b00, input int b01, input int b10, input int b11);
        randomFill(1'b1);
        ma[0][0] = a00; ma[0][1] = a01; ma[1][0] = a10; ma[1][1] = a11;
        mb[0][0] = b00; mb[0][1] = b01; mb[1][0] = b10; mb[1][1] = b11;
    endtask

    task automatic waitDone();
        for (int i = 0; i < MAX_WAIT && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            tests_run++;
            failed++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles, %0d results outstanding", MAX_WAIT, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Inputs are scrambled right after the start edge; poke re-pulses start mid-operation.
    task automatic applyStimulus(input int op, input int n, input bit sat, input int s, input bit poke, input int abort_at);
        exp_t e;
        @(negedge clock);
        model(op, n, sat, s, e);
        e.start_cyc = cyc;
        e.id        = next_id;
        next_id++;
        loadOperands();
        bus.opcode      = 3'(op);
        bus.matrix_size = SIZE_W'(n);
        bus.sat_mode    = sat;
        bus.scalar      = DATA_W'(s);
        bus.start       = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        bus.start       = 1'b0;
        bus.A_flat      = ~bus.A_flat;
        bus.B_flat      = ~bus.B_flat;
        bus.opcode      = bus.opcode + 3'd1;
        bus.matrix_size = bus.matrix_size + SIZE_W'(1);
        bus.sat_mode    = ~sat;
        bus.scalar      = ~bus.scalar;
        if (poke) begin
            @(negedge clock);
            bus.start = 1'b1;
            @(negedge clock);
            bus.start = 1'b0;
        end
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clock);
            reset = 1'b1;
            #1;
            checkOutput("abort_C_flat", e.id, bus.C_flat, '0);
            checkOutput("abort_busy", e.id, FLAT_W'(bus.busy), '0);
            checkOutput("abort_done", e.id, FLAT_W'(bus.done), '0);
            checkOutput("abort_overflow", e.id, FLAT_W'(bus.overflow_flag), '0);
            checkOutput("abort_error", e.id, FLAT_W'(bus.error), '0);
            exp_q.delete();
            @(negedge clock);
            reset = 1'b0;
        end else begin
            waitDone();
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.done) begin
            checkOutput("done_pulse_width", -1, FLAT_W'(prev_done), '0);
            checkOutput("busy_at_done", -1, FLAT_W'(bus.busy), FLAT_W'(1));
            if (exp_q.size() == 0) begin
                tests_run++;
                failed++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no completion pending");
            end else begin
                e = exp_q.pop_front();
                checkOutput("C_flat", e.id, bus.C_flat, e.c);
                checkOutput("overflow_flag", e.id, FLAT_W'(bus.overflow_flag), FLAT_W'(e.ovf));
                checkOutput("error", e.id, FLAT_W'(bus.error), FLAT_W'(e.err));
                if (e.lat >= 0) begin
                    checkOutput("done_latency", e.id, FLAT_W'(cyc - e.start_cyc - 1), FLAT_W'(e.lat));
                end
            end
        end
        prev_done <= bus.done;
    end

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.opcode      = '0;
        bus.matrix_size = '0;
        bus.sat_mode    = 1'b0;
        bus.scalar      = '0;
        bus.A_flat      = '0;
        bus.B_flat      = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_C_flat", -1, bus.C_flat, '0);
        checkOutput("reset_busy", -1, FLAT_W'(bus.busy), '0);
        checkOutput("reset_done", -1, FLAT_W'(bus.done), '0);
        checkOutput("reset_overflow", -1, FLAT_W'(bus.overflow_flag), '0);
        checkOutput("reset_error", -1, FLAT_W'(bus.error), '0);
        reset = 1'b0;

        set2(1, 2, 3, 4, 2, 5, -1, 1);
        applyStimulus(1, 2, 1'b0, 0, 1'b0, 0);
        applyStimulus(3, 2, 1'b0, 0, 1'b0, 0);

        randomFill(1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) ma[r][c] = (r == c) ? 1 : 0;
        end
        applyStimulus(3, 3, 1'b0, 0, 1'b1, 0);

        set2(1, -1, 127, -128, 1, 1, 1, 1);
        applyStimulus(1, 2, 1'b0, 0, 1'b0, 0);
        applyStimulus(1, 2, 1'b1, 0, 1'b0, 0);
        ma[0][0] = -128;
        applyStimulus(4, 1, 1'b1, 0, 1'b0, 0);

        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                ma[r][c] = r * MAX_N + c + 1;
                mb[r][c] = r * MAX_N + c + 1;
            end
        end
        applyStimulus(5, 5, 1'b0, 0, 1'b0, 0);
        applyStimulus(6, 4, 1'b0, 2, 1'b0, 0);

        applyStimulus(7, 2, 1'b0, 0, 1'b0, 0);
        applyStimulus(1, 6, 1'b0, 0, 1'b0, 0);
        applyStimulus(0, 3, 1'b0, 0, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            int op;
            int n;
            int s;
            bit sat;
            bit wide;
            wide = 1'($urandom_range(0, 1));
            randomFill(wide);
            op = int'($urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0) op = ($urandom_range(0, 1) == 0) ? 0 : 7;
            n = int'($urandom_range(1, MAX_N));
            if ($urandom_range(0, 14) == 0) n = int'($urandom_range(0, 1)) * 6;
            sat = 1'($urandom_range(0, 1));
            s = wide ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 8)) - 4;
            applyStimulus(op, n, sat, s, 1'b0, 0);
        end

        randomFill(1'b1);
        applyStimulus(3, 5, 1'b0, 0, 1'b0, 40);
        set2(1, 2, 3, 4, 2, 5, -1, 1);
        applyStimulus(1, 2, 1'b0, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
